// File: rtl/spi_adc_reader.sv
// SPI master receiver for the clap-detect ADC, valid/ready sample output.
// SPI_ADC_READER_FREERUN_EN: fixed-rate frames plus sticky overrun flag.
module spi_adc_reader #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int CLOCK_DIVIDE   = 4,
  parameter int CS_IDLE_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    enable,
  output logic                    spi_clock,
  output logic                    spi_chipselect,
  input  logic                    spi_data,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_valid,
  input  logic                    sample_ready
`ifdef SPI_ADC_READER_FREERUN_EN
  ,
  output logic                    overrun
`endif
);

  localparam int DW = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam int BW = $clog2(SAMPLE_WIDTH + 1);
  localparam int GW = $clog2(CS_IDLE_CYCLES) + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIVIDE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SAMPLE_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_LOW_WAIT,
    S_HIGH_WAIT,
    S_DONE
  } state_t;

  state_t                  state, state_n;
  logic [DW-1:0]           div, div_n;
  logic [BW-1:0]           bit_cnt, bit_n;
  logic [GW-1:0]           gap_cnt, gap_n;
  logic [SAMPLE_WIDTH-1:0] shreg, shift_n;
  logic [SAMPLE_WIDTH-1:0] data_n;
  logic                    sclk_n;
  logic                    cs_n;
  logic                    valid_n;
  logic                    tick;
  logic [DW-1:0]           div_adv;
  logic                    start_ok;

  assign tick    = (div == DIV_LAST);
  assign div_adv = tick ? '0 : div + DW'(1);

`ifdef SPI_ADC_READER_FREERUN_EN
  logic ovr_n;
  assign start_ok = 1'b1;
`else
  // Never start a frame that could complete onto an unconsumed word.
  assign start_ok = ~sample_valid | sample_ready;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state          <= S_IDLE;
      div            <= '0;
      bit_cnt        <= '0;
      gap_cnt        <= '0;
      shreg          <= '0;
      spi_clock      <= 1'b1;
      spi_chipselect <= 1'b1;
      sample_data    <= '0;
      sample_valid   <= 1'b0;
`ifdef SPI_ADC_READER_FREERUN_EN
      overrun        <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      div            <= div_n;
      bit_cnt        <= bit_n;
      gap_cnt        <= gap_n;
      shreg          <= shift_n;
      spi_clock      <= sclk_n;
      spi_chipselect <= cs_n;
      sample_data    <= data_n;
      sample_valid   <= valid_n;
`ifdef SPI_ADC_READER_FREERUN_EN
      overrun        <= ovr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    shift_n = shreg;
    sclk_n  = spi_clock;
    cs_n    = spi_chipselect;
    data_n  = sample_data;
    valid_n = sample_valid & ~sample_ready;
`ifdef SPI_ADC_READER_FREERUN_EN
    ovr_n   = overrun;
`endif
    unique case (state)
      S_IDLE: begin
        cs_n    = 1'b1;
        sclk_n  = 1'b1;
        div_n   = '0;
        gap_n   = '0;
        state_n = S_GAP;
      end
      S_GAP: begin
        div_n = '0;
        if (gap_cnt != GAP_LAST) begin
          gap_n = gap_cnt + GW'(1);
        end else if (enable && start_ok) begin
          cs_n    = 1'b0;
          state_n = S_LOW_WAIT;
        end
      end
      S_LOW_WAIT: begin
        div_n = div_adv;
        if (tick) begin
          sclk_n  = 1'b0;
          state_n = S_HIGH_WAIT;
        end
      end
      S_HIGH_WAIT: begin
        div_n = div_adv;
        if (tick) begin
          sclk_n  = 1'b1;
          shift_n = {shreg[SAMPLE_WIDTH-2:0], spi_data};
          bit_n   = bit_cnt + BW'(1);
          state_n = (bit_cnt == BIT_LAST) ? S_DONE : S_LOW_WAIT;
        end
      end
      S_DONE: begin
        div_n = div_adv;
        // First DONE cycle: publish the word one edge after the last capture.
        if (div == '0) begin
          data_n  = shreg;
          valid_n = 1'b1;
`ifdef SPI_ADC_READER_FREERUN_EN
          if (sample_valid && !sample_ready) ovr_n = 1'b1;
`endif
        end
        if (tick) begin
          cs_n    = 1'b1;
          bit_n   = '0;
          gap_n   = '0;
          state_n = S_GAP;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Bench for spi_adc_reader: ADC slave model, timing monitor, scoreboard.
// Vector table, hand sequences and randomized ready stalls.
module tb_spi_adc_reader;

  localparam int W       = 16;
  localparam int D       = 4;
  localparam int G       = 2;
  localparam int LOAD_AT = 2 * W * D + 1;
  localparam int CSUP_AT = (2 * W + 1) * D;

  logic         clock = 1'b0;
  logic         nreset = 1'b1;
  logic         enable = 1'b0;
  logic         spi_data = 1'b0;
  logic         sample_ready = 1'b0;
  logic         spi_clock;
  logic         spi_chipselect;
  logic         sample_valid;
  logic [W-1:0] sample_data;
`ifdef SPI_ADC_READER_FREERUN_EN
  logic         overrun;
`endif

  spi_adc_reader #(
    .SAMPLE_WIDTH  (W),
    .CLOCK_DIVIDE  (D),
    .CS_IDLE_CYCLES(G)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .enable        (enable),
    .spi_clock     (spi_clock),
    .spi_chipselect(spi_chipselect),
    .spi_data      (spi_data),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready)
`ifdef SPI_ADC_READER_FREERUN_EN
    ,
    .overrun       (overrun)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  logic [W-1:0] tx_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] cur_word = '0;
  int           idx = 0;

  // ADC slave: new word per frame, next bit after each falling spi_clock
  always @(negedge spi_chipselect) begin
    if (tx_q.size() > 0) cur_word = tx_q.pop_front();
    else cur_word = W'($urandom);
    idx = W - 1;
    exp_q.push_back(cur_word);
  end

  always @(negedge spi_clock) begin
    if (!spi_chipselect && idx >= 0) begin
      spi_data = cur_word[idx];
      idx--;
    end
  end

  logic         p_cs = 1'b1, p_sclk = 1'b1, p_valid = 1'b0, p_ready = 1'b0;
  logic [W-1:0] p_data = '0;
  int           t0 = 0, rises = 0, falls = 0, cs_falls = 0;
  int           gap_cyc = 0, acc_cnt = 0;
  bit           frame_live = 1'b0;
  bit           sb_on = 1'b1;

  // Monitor: frame timing from the T0 chip-select fall, handshake, scoreboard
  always @(negedge clock) begin
    int dt;
    bit load_now;
    if (nreset) begin
      if (p_cs && !spi_chipselect) begin
        check("cs_gap", gap_cyc >= G, 1);
`ifndef SPI_ADC_READER_FREERUN_EN
        check("flow_ctrl", !p_valid || p_ready, 1);
`endif
        t0 = cyc;
        frame_live = 1'b1;
        rises = 0;
        falls = 0;
        gap_cyc = 0;
        cs_falls++;
      end
      dt = cyc - t0;
      load_now = frame_live && dt == LOAD_AT;
      if (frame_live && p_sclk && !spi_clock) begin
        check("sclk_fall_time", dt, (2 * falls + 1) * D);
        falls++;
      end
      if (frame_live && !p_sclk && spi_clock) begin
        check("sclk_rise_time", dt, (2 * rises + 2) * D);
        rises++;
      end
      if (frame_live && !p_cs && spi_chipselect) begin
        check("cs_rise_time", dt, CSUP_AT);
        check("rise_count", rises, W);
        check("fall_count", falls, W);
        frame_live = 1'b0;
      end
      if (load_now) begin
        check("valid_at_load", sample_valid, 1);
        check("load_word", sample_data, cur_word);
      end else if (p_valid && !p_ready) begin
        check("hold_valid", sample_valid, 1);
        check("hold_data", sample_data, p_data);
      end else if (p_valid && p_ready) begin
        check("valid_clear", sample_valid, 0);
      end
      if (sample_valid && sample_ready) begin
        acc_cnt++;
        got_q.push_back(sample_data);
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_word: accepted %h, required no word", sample_data);
          end else begin
            check("sb_word", sample_data, exp_q.pop_front());
          end
        end
      end
    end else begin
      frame_live = 1'b0;
    end
    if (spi_chipselect) gap_cyc++;
    p_cs    = spi_chipselect;
    p_sclk  = spi_clock;
    p_valid = sample_valid;
    p_ready = sample_ready;
    p_data  = sample_data;
  end

  task automatic wait_idle();
    int stable = 0;
    enable = 1'b0;
    sample_ready = 1'b1;
    for (int i = 0; i < 600 && stable < 4; i++) begin
      @(posedge clock);
      #1;
      if (spi_chipselect && !sample_valid) stable++;
      else stable = 0;
    end
    check("idle_reached", stable >= 4, 1);
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   f0;
    int   r;
    int   a0;
    vecs[0] = '{word: 16'hA5C3, exp: 16'hA5C3};
    vecs[1] = '{word: 16'h0000, exp: 16'h0000};
    vecs[2] = '{word: 16'hFFFF, exp: 16'hFFFF};
    vecs[3] = '{word: 16'h8001, exp: 16'h8001};
    vecs[4] = '{word: 16'h5A5A, exp: 16'h5A5A};
    vecs[5] = '{word: 16'h1234, exp: 16'h1234};

    #2 nreset = 1'b0;
    #1;
    check("rst_cs", spi_chipselect, 1);
    check("rst_sclk", spi_clock, 1);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
`ifdef SPI_ADC_READER_FREERUN_EN
    check("rst_overrun", overrun, 0);
`endif
    repeat (2) @(posedge clock);
    #1 nreset = 1'b1;

    // Vector table, run back to back
    sample_ready = 1'b1;
    got_q.delete();
    foreach (vecs[i]) tx_q.push_back(vecs[i].word);
    enable = 1'b1;
    for (int i = 0; i < 1200 && got_q.size() < 6; i++) @(posedge clock);
    check("table_done", got_q.size() >= 6, 1);
    wait_idle();
    for (int i = 0; i < 6; i++)
      check($sformatf("vec%0d", i), (got_q.size() > i) ? got_q[i] : 'x,
            vecs[i].exp);

`ifndef SPI_ADC_READER_FREERUN_EN
    // Consumer stalls: no new frame until the word is taken
    got_q.delete();
    sample_ready = 1'b0;
    tx_q.push_back(16'h1234);
    tx_q.push_back(16'hBEEF);
    enable = 1'b1;
    for (int i = 0; i < 300 && !sample_valid; i++) begin
      @(posedge clock);
      #1;
    end
    check("stall_valid", sample_valid, 1);
    f0 = cs_falls;
    repeat (300) @(posedge clock);
    #1;
    check("stall_no_start", cs_falls, f0);
    check("stall_hold_valid", sample_valid, 1);
    check("stall_hold_data", sample_data, 16'h1234);
    r = cyc;
    sample_ready = 1'b1;
    for (int i = 0; i < 10 && cs_falls == f0; i++) begin
      @(posedge clock);
      #1;
    end
    check("restart_seen", cs_falls != f0, 1);
    check("restart_latency", (t0 - r >= 1) && (t0 - r <= 3), 1);
    enable = 1'b0;
    wait_idle();
    check("stall_word0", (got_q.size() > 0) ? got_q[0] : 'x, 16'h1234);
    check("stall_word1", (got_q.size() > 1) ? got_q[1] : 'x, 16'hBEEF);
`endif

    // enable drops during bit 3: frame completes, then stays idle
    got_q.delete();
    sample_ready = 1'b1;
    tx_q.push_back(16'h3C3C);
    f0 = cs_falls;
    enable = 1'b1;
    for (int i = 0; i < 300 && !(cs_falls != f0 && rises >= 3); i++) begin
      @(posedge clock);
      #1;
    end
    check("en_drop_bit3", rises, 3);
    enable = 1'b0;
    for (int i = 0; i < 200 && got_q.size() < 1; i++) @(posedge clock);
    check("en_drop_word", (got_q.size() > 0) ? got_q[0] : 'x, 16'h3C3C);
    f0 = cs_falls;
    repeat (300) @(posedge clock);
    #1;
    check("en_drop_no_start", cs_falls, f0);
    check("en_drop_cs_high", spi_chipselect, 1);

    // Reset in the middle of bit 7 aborts the frame
    tx_q.push_back(16'hDEAD);
    f0 = cs_falls;
    enable = 1'b1;
    for (int i = 0; i < 300 && !(cs_falls != f0 && rises >= 7); i++) begin
      @(posedge clock);
      #1;
    end
    check("mid_rst_bit7", rises, 7);
    repeat (5) @(posedge clock);
    #3;
    check("mid_rst_sclk_low", spi_clock, 0);
    nreset = 1'b0;
    #1;
    check("mid_rst_cs", spi_chipselect, 1);
    check("mid_rst_sclk", spi_clock, 1);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_data", sample_data, 0);
    exp_q.delete();
    got_q.delete();
    tx_q.push_back(16'h5A5A);
    repeat (3) @(posedge clock);
    #1 nreset = 1'b1;
    for (int i = 0; i < 400 && got_q.size() < 1; i++) @(posedge clock);
    check("post_rst_word", (got_q.size() > 0) ? got_q[0] : 'x, 16'h5A5A);
    wait_idle();

    // Random words with random consumer stalls, checked by the scoreboard
    for (int i = 0; i < 20; i++) tx_q.push_back(W'($urandom));
    a0 = acc_cnt;
    enable = 1'b1;
    for (int i = 0; i < 8000 && acc_cnt - a0 < 20; i++) begin
      @(posedge clock);
      #1;
`ifdef SPI_ADC_READER_FREERUN_EN
      sample_ready = 1'b1;
`else
      sample_ready = ($urandom_range(0, 3) != 0);
`endif
    end
    check("random_done", acc_cnt - a0 >= 20, 1);
    wait_idle();
    check("sb_drained", exp_q.size(), 0);

`ifdef SPI_ADC_READER_FREERUN_EN
    // Fixed-rate frames overwrite an unconsumed word and flag overrun
    sb_on = 1'b0;
    sample_ready = 1'b0;
    tx_q.push_back(16'h1111);
    tx_q.push_back(16'h2222);
    f0 = cs_falls;
    enable = 1'b1;
    for (int i = 0; i < 300 && !sample_valid; i++) begin
      @(posedge clock);
      #1;
    end
    check("fr_first_word", sample_data, 16'h1111);
    check("fr_no_overrun_yet", overrun, 0);
    for (int i = 0; i < 300 && cs_falls < f0 + 2; i++) begin
      @(posedge clock);
      #1;
    end
    check("fr_second_start", cs_falls, f0 + 2);
    enable = 1'b0;
    repeat (140) @(posedge clock);
    #1;
    check("fr_second_word", sample_data, 16'h2222);
    check("fr_valid", sample_valid, 1);
    check("fr_overrun", overrun, 1);
    sample_ready = 1'b1;
    @(posedge clock);
    #1 sample_ready = 1'b0;
    check("fr_accept_clears", sample_valid, 0);
    check("fr_overrun_sticky", overrun, 1);
    exp_q.delete();
    sb_on = 1'b1;
    wait_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d",
             n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/spi_adc_reader.md
Name: spi_adc_reader

Overview:
- SPI master receiver for the serial ADC feeding the clap-detect path.
- Generates spi_chipselect and spi_clock, shifts in SAMPLE_WIDTH bits MSB-first on spi_data, and presents each word on a valid/ready output port to the downstream sample consumer.
- It is the counterpart of the ADC model: the slave drives a new bit after each spi_clock falling edge, and this block captures it on the following rising edge.

Parameters:
- SAMPLE_WIDTH, 16, bits per frame and width of sample_data.
- CLOCK_DIVIDE, 4, system clocks per spi_clock half-period; minimum 2.
- CS_IDLE_CYCLES, 2, minimum system clocks spi_chipselect stays high between frames; minimum 1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- nreset  in  1  asynchronous active-low reset.
- enable  in  1  high = run frames back to back; low = finish the current frame, then idle.
- spi_clock  out  1  SPI clock; idles high.
- spi_chipselect  out  1  active-low chip select.
- spi_data  in  1  serial data from the ADC; MSB first.
- sample_data  out  SAMPLE_WIDTH  captured word.
- sample_valid  out  1  sample_data holds an unconsumed word.
- sample_ready  in  1  consumer accepts the word when sample_valid and sample_ready are both high.

Behaviour:
- Reset (asynchronous, nreset=0): spi_chipselect=1, spi_clock=1, sample_valid=0, sample_data=0, shift register=0, divider=0, bit counter=0, state=IDLE. Reset mid-frame aborts immediately: chip select rises in the same instant and no partial word is output.
- Divider counts 0..CLOCK_DIVIDE-1. Each wrap is one half-period "tick".
- State machine:
  - IDLE: chip select and clock high. Go to GAP.
  - GAP: chip select high for at least CS_IDLE_CYCLES cycles. When that count is met, enable=1, and the output is free, then on the next edge drive spi_chipselect=0 (cycle T0) and enter LOW_WAIT.
  - Output free means sample_valid=0, or sample_valid&sample_ready in that cycle.
  - If enable=0, stay in GAP.
  - LOW_WAIT: after CLOCK_DIVIDE cycles drive spi_clock=0, then go to HIGH_WAIT.
  - HIGH_WAIT: after CLOCK_DIVIDE cycles drive spi_clock=1 and, on that same edge, shift spi_data into the LSB of the shift register (previous bits move left). Increment the bit counter.
    - If the counter is below SAMPLE_WIDTH, return to LOW_WAIT.
    - Otherwise go to DONE.
  - DONE: load sample_data from the shift register and set sample_valid=1 on the edge after the last capture. After CLOCK_DIVIDE cycles from the last rising spi_clock, raise spi_chipselect, clear the bit counter, and go to GAP.
- Frame timing, relative to the T0 edge where chip select falls:
  - Bit k (k=0 is the MSB) is captured at T0+(2k+2)*CLOCK_DIVIDE.
  - sample_valid rises at T0+2*SAMPLE_WIDTH*CLOCK_DIVIDE+1.
  - Chip select rises at T0+(2*SAMPLE_WIDTH+1)*CLOCK_DIVIDE.
  - Exactly SAMPLE_WIDTH falling and SAMPLE_WIDTH rising spi_clock edges occur per frame.
- spi_data is sampled directly, without a synchronizer. The slave guarantees the data is stable for CLOCK_DIVIDE cycles before each rising edge.
- Output handshake:
  - sample_valid stays high, with sample_data stable, until accepted.
  - On acceptance with no new word completing, sample_valid clears on the next edge.
  - If a word completes in the same cycle as an acceptance, the new word loads and sample_valid stays 1.
- enable falling mid-frame does not abort the frame. The frame completes and the block then holds in GAP.
- Default flow control: a frame never starts while the output is occupied and not being accepted, so no word is ever lost.

Optional Feature:
- Macro: SPI_ADC_READER_FREERUN_EN.
- Defined:
  - Frames start whenever the GAP timing is met and enable=1, regardless of output occupancy, giving a fixed sample rate.
  - If a frame completes while sample_valid=1 and sample_ready=0, sample_data is overwritten and a sticky output overrun (1 bit, reset 0) is set. overrun is cleared only by nreset.
- Undefined: the overrun port does not exist, and the flow-control rule above applies.

Test Plan (CLOCK_DIVIDE=4, CS_IDLE_CYCLES=2, SAMPLE_WIDTH=16):
- Reset, then enable=1 and sample_ready=1; slave model drives 0xA5C3 on spi_clock falls -> sample_valid pulses for one cycle at T0+129 with sample_data=0xA5C3, chip select rises at T0+132, and exactly 16 rising spi_clock edges are counted.
- Back-to-back words 0x0000, 0xFFFF, 0x8001 with sample_ready=1 -> three words received in order, and chip select is high for at least 2 cycles between frames.
- sample_ready=0 after word 0x1234 -> sample_valid held with 0x1234 and no new chip-select fall; raise ready -> word accepted, next frame starts within 3 cycles.
- nreset pulsed at bit 7 of a frame -> spi_chipselect=1 and spi_clock=1 immediately, sample_valid=0; the next full frame 0x5A5A is received correctly.
- enable dropped during bit 3 -> current frame completes and its word is delivered, then chip select stays high while enable=0.
- With SPI_ADC_READER_FREERUN_EN and sample_ready=0, two frames 0x1111 then 0x2222 -> sample_data=0x2222, overrun=1, and it stays 1 after a later acceptance.
